// File: rtl/md5_block_padder.sv
// md5_block_padder
// Streams an arbitrary-length message in DATA_W-bit beats and emits MD5 (RFC 1321) padded
// 512-bit blocks, with first/last flags for the compression core.
//
// Ports:
//   i_clk, i_reset        rising-edge clock, synchronous active-high reset
//   i_msg_in              message beat, first byte in i_msg_in[0:7]
//   i_msg_in_bytes        valid bytes in the beat (left-justified)
//   i_msg_in_valid        beat valid
//   i_msg_in_last         final beat of the message
//   o_ready               beat accepted on an edge where valid & ready
//   o_blk_out             padded block, byte k at o_blk_out[8k:8k+7]
//   o_blk_out_valid       block valid
//   o_blk_out_first       first block of the message
//   o_blk_out_last        final block (holds the length field)
//   i_blk_out_ready       downstream accept
//   o_err                 sticky protocol error (only with MD5_PAD_ERR_EN defined)
//
// Optional feature macro: MD5_PAD_ERR_EN (protocol checking and the o_err port).

module md5_block_padder #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned LEN_W  = 61
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [0:DATA_W-1]             i_msg_in,
  input  logic [$clog2(DATA_W/8):0]     i_msg_in_bytes,
  input  logic                          i_msg_in_valid,
  input  logic                          i_msg_in_last,
  output logic                          o_ready,
  output logic [0:511]                  o_blk_out,
  output logic                          o_blk_out_valid,
  output logic                          o_blk_out_first,
  output logic                          o_blk_out_last,
  input  logic                          i_blk_out_ready
`ifdef MD5_PAD_ERR_EN
  ,
  output logic                          o_err
`endif
);

  localparam int unsigned BEAT_B = DATA_W / 8;
  localparam int unsigned BW     = $clog2(BEAT_B) + 1;
  localparam int unsigned SLOTS  = 64 / BEAT_B;

  typedef enum logic [1:0] {StFill, StOutData, StOutPad, StOutFinal} state_t;

  state_t           r_state;
  logic [6:0]       r_ptr;
  logic [LEN_W-1:0] r_cnt;
  logic             r_first_pend;
  logic             r_need80;
  logic             r_ready;
  logic             r_valid;
  logic             r_first;
  logic             r_last;
  logic             r_err;
  logic [7:0]       r_buf [64];

  logic [7:0]       w_buf [64];
  logic [7:0]       w_len [8];
  logic [BW-1:0]    w_bytes;
  logic [6:0]       w_n;
  logic [6:0]       w_t;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic [63:0]      w_bitlen;
  logic             w_accept;
  logic             w_illegal;

  always_comb begin
    w_accept  = i_msg_in_valid & r_ready;
    w_bytes   = (i_msg_in_bytes > BW'(BEAT_B)) ? BW'(BEAT_B) : i_msg_in_bytes;
    w_n       = i_msg_in_last ? 7'(w_bytes) : 7'(BEAT_B);
    w_t       = r_ptr + w_n;
    w_cnt_nxt = r_cnt + LEN_W'(w_n);
`ifdef MD5_PAD_ERR_EN
    w_illegal = (!i_msg_in_last && (i_msg_in_bytes != BW'(BEAT_B))) ||
                (i_msg_in_bytes > BW'(BEAT_B));
`else
    w_illegal = 1'b0;
`endif
    // In FILL the length must include the beat being accepted.
    w_bitlen = (r_state == StFill) ? (64'(w_cnt_nxt) << 3) : (64'(r_cnt) << 3);
    for (int i = 0; i < 8; i++) begin
      w_len[i] = w_bitlen[8*i +: 8];
    end

    w_buf = r_buf;
    if (r_state == StFill) begin
      // ptr is always a whole number of beats, so each beat lands in one aligned slot.
      for (int s = 0; s < SLOTS; s++) begin
        for (int j = 0; j < BEAT_B; j++) begin
          if (r_ptr == 7'(s * BEAT_B) && 7'(j) < w_n) begin
            w_buf[s*BEAT_B + j] = i_msg_in[8*j +: 8];
          end
        end
      end
      if (i_msg_in_last) begin
        for (int k = 0; k < 56; k++) begin
          if (7'(k) == w_t) begin
            w_buf[k] = 8'h80;
          end else if (7'(k) > w_t) begin
            w_buf[k] = 8'h00;
          end
        end
        for (int i = 0; i < 8; i++) begin
          if (w_t <= 7'd55) begin
            w_buf[56+i] = w_len[i];
          end else if (7'(56 + i) == w_t) begin
            w_buf[56+i] = 8'h80;
          end else if (7'(56 + i) > w_t) begin
            w_buf[56+i] = 8'h00;
          end
        end
      end
    end else if (r_state == StOutPad) begin
      w_buf[0] = r_need80 ? 8'h80 : 8'h00;
      for (int k = 1; k < 56; k++) begin
        w_buf[k] = 8'h00;
      end
      for (int i = 0; i < 8; i++) begin
        w_buf[56+i] = w_len[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StFill;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_first_pend <= 1'b1;
      r_need80     <= 1'b0;
      r_ready      <= 1'b0;
      r_valid      <= 1'b0;
      r_first      <= 1'b0;
      r_last       <= 1'b0;
      r_err        <= 1'b0;
      r_buf        <= '{default: 8'h00};
    end else begin
      unique case (r_state)
        StFill: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (w_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_buf <= w_buf;
              r_cnt <= w_cnt_nxt;
              r_ptr <= w_t;
              if (i_msg_in_last) begin
                r_need80 <= (w_t == 7'd64);
                r_ready  <= 1'b0;
                r_valid  <= 1'b1;
                r_first  <= r_first_pend;
                r_last   <= (w_t <= 7'd55);
                r_state  <= (w_t <= 7'd55) ? StOutFinal : StOutPad;
              end else if (w_t == 7'd64) begin
                r_ready <= 1'b0;
                r_valid <= 1'b1;
                r_first <= r_first_pend;
                r_last  <= 1'b0;
                r_state <= StOutData;
              end
            end
          end
        end
        StOutData: begin
          if (i_blk_out_ready) begin
            r_ptr        <= '0;
            r_first_pend <= 1'b0;
            r_valid      <= 1'b0;
            r_first      <= 1'b0;
            r_ready      <= 1'b1;
            r_state      <= StFill;
          end
        end
        StOutPad: begin
          if (i_blk_out_ready) begin
            r_buf        <= w_buf;
            r_first_pend <= 1'b0;
            r_first      <= 1'b0;
            r_last       <= 1'b1;
            r_state      <= StOutFinal;
          end
        end
        StOutFinal: begin
          if (i_blk_out_ready) begin
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_need80     <= 1'b0;
            r_first_pend <= 1'b1;
            r_valid      <= 1'b0;
            r_first      <= 1'b0;
            r_last       <= 1'b0;
            r_ready      <= 1'b1;
            r_state      <= StFill;
          end
        end
        default: r_state <= StFill;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < 64; k++) begin
      o_blk_out[8*k +: 8] = r_buf[k];
    end
  end

  assign o_ready         = r_ready;
  assign o_blk_out_valid = r_valid;
  assign o_blk_out_first = r_first;
  assign o_blk_out_last  = r_last;

`ifdef MD5_PAD_ERR_EN
  assign o_err = r_err;
`else
  logic w_err_unused;
  assign w_err_unused = r_err;
`endif

endmodule

// File: tb/tb_md5_block_padder.sv
// Self-checking bench for md5_block_padder: random and boundary-length messages are padded by a
// byte-queue reference model and compared block by block against the DUT output.
module tb_md5_block_padder;

  localparam int unsigned DW     = 128;
  localparam int unsigned BEAT_B = DW / 8;
  localparam int unsigned BW     = $clog2(BEAT_B) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [0:DW-1]   msg_in;
  logic [BW-1:0]   msg_bytes;
  logic            msg_valid;
  logic            msg_last;
  logic            ready;
  logic [0:511]    blk;
  logic            blk_valid;
  logic            blk_first;
  logic            blk_last;
  logic            blk_ready;
`ifdef MD5_PAD_ERR_EN
  logic            err;
`endif

  always #5 clk = ~clk;

  md5_block_padder #(
    .DATA_W (DW),
    .LEN_W  (61)
  ) u_dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_msg_in        (msg_in),
    .i_msg_in_bytes  (msg_bytes),
    .i_msg_in_valid  (msg_valid),
    .i_msg_in_last   (msg_last),
    .o_ready         (ready),
    .o_blk_out       (blk),
    .o_blk_out_valid (blk_valid),
    .o_blk_out_first (blk_first),
    .o_blk_out_last  (blk_last),
    .i_blk_out_ready (blk_ready)
`ifdef MD5_PAD_ERR_EN
    ,
    .o_err           (err)
`endif
  );

  typedef logic [7:0] bq_t [$];
  typedef struct {
    logic [0:511] data;
    logic         first;
    logic         last;
  } exp_t;

  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   abort = 1'b0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bq_t rand_msg(input int len);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit LE bit length, cut into blocks.
  task automatic build_expected(input bq_t msg);
    bq_t         p;
    logic [63:0] bl;
    int          nb;
    exp_t        e;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int i = 0; i < 8; i++) p.push_back(bl[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 64; k++) e.data[8*k +: 8] = p[64*b + k];
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge with a beat presented; returns at the negedge after the accepting edge.
  task automatic wait_accept(output bit ok);
    int budget = 2000;
    ok = 1'b0;
    while (!ready) begin
      if (abort) return;
      if (budget == 0) begin
        check_eq("beat_timeout", 0, 1);
        return;
      end
      @(negedge clk);
      budget--;
    end
    @(negedge clk);
    ok = 1'b1;
  endtask

  task automatic drive_msg(input bq_t msg, input bit empty_tail, input bit gaps);
    int            pos = 0;
    int            rem;
    int            n;
    bit            last;
    bit            ok;
    logic [0:DW-1] beat;
    do begin
      rem = msg.size() - pos;
      if (rem > int'(BEAT_B) || (rem == int'(BEAT_B) && empty_tail)) begin
        n = BEAT_B;
        last = 1'b0;
      end else begin
        n = rem;
        last = 1'b1;
      end
      if (gaps) repeat ($urandom_range(2)) @(negedge clk);
      for (int j = 0; j < int'(BEAT_B); j++) begin
        if (j < n) beat[8*j +: 8] = msg[pos + j];
        else       beat[8*j +: 8] = 8'($urandom);
      end
      msg_in    = beat;
      msg_bytes = BW'(n);
      msg_last  = last;
      msg_valid = 1'b1;
      wait_accept(ok);
      msg_valid = 1'b0;
      if (!ok) return;
      pos += n;
    end while (!last);
  endtask

  task automatic run_collect(input int bp_pct);
    int   budget = 3000;
    exp_t e;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      blk_ready = ($urandom_range(99) >= bp_pct);
      if (blk_valid && blk_ready) begin
        e = exp_q.pop_front();
        check_eq("blk_data", blk, e.data);
        check_eq("blk_first", blk_first, e.first);
        check_eq("blk_last", blk_last, e.last);
      end
      budget--;
    end
    if (exp_q.size() != 0) check_eq("blk_timeout", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    blk_ready = 1'b0;
    check_eq("idle_valid", blk_valid, 0);
    check_eq("idle_ready", ready, 1);
  endtask

  task automatic run_msg(input bq_t msg, input bit empty_tail, input bit gaps, input int bp);
    build_expected(msg);
    fork
      drive_msg(msg, empty_tail, gaps);
      run_collect(bp);
    join
  endtask

  task automatic wait_valid();
    int b = 0;
    while (!blk_valid && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (!blk_valid) check_eq("valid_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t          m;
    bq_t          abc;
    logic [0:511] snap;
    logic         snap_f;
    logic         snap_l;
    int           bounds [16] = '{0, 1, 15, 16, 47, 48, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128};

    rst = 1'b1;
    msg_in = '0;
    msg_bytes = '0;
    msg_valid = 1'b0;
    msg_last = 1'b0;
    blk_ready = 1'b0;
    abc.push_back(8'h61);
    abc.push_back(8'h62);
    abc.push_back(8'h63);

    repeat (3) @(negedge clk);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_valid", blk_valid, 0);
    check_eq("rst_first", blk_first, 0);
    check_eq("rst_last", blk_last, 0);
    check_eq("rst_blk", blk, 512'h0);
`ifdef MD5_PAD_ERR_EN
    check_eq("rst_err", err, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", ready, 1);

    run_msg(abc, 1'b0, 1'b0, 0);
    m.delete();
    run_msg(m, 1'b0, 1'b0, 0);
    run_msg(rand_msg(56), 1'b0, 1'b0, 0);
    run_msg(rand_msg(64), 1'b0, 1'b0, 0);
    run_msg(rand_msg(64), 1'b1, 1'b0, 0);
    run_msg(rand_msg(55), 1'b0, 1'b0, 0);

    // Backpressure: hold the first block for five cycles, then drain with random stalls.
    m = rand_msg(200);
    build_expected(m);
    fork
      drive_msg(m, 1'b0, 1'b0);
      begin
        blk_ready = 1'b0;
        wait_valid();
        snap = blk;
        snap_f = blk_first;
        snap_l = blk_last;
        repeat (5) begin
          @(negedge clk);
          check_eq("bp_blk", blk, snap);
          check_eq("bp_first", blk_first, snap_f);
          check_eq("bp_last", blk_last, snap_l);
          check_eq("bp_ready", ready, 0);
        end
        run_collect(30);
      end
    join

    // Reset while the first block of a two-block message is waiting.
    m = rand_msg(100);
    fork
      drive_msg(m, 1'b0, 1'b0);
      begin
        blk_ready = 1'b0;
        wait_valid();
        abort = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_ready", ready, 0);
        check_eq("mid_rst_valid", blk_valid, 0);
        @(negedge clk);
      end
    join
    rst = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_ready_after", ready, 1);
    run_msg(abc, 1'b0, 1'b0, 0);

`ifdef MD5_PAD_ERR_EN
    begin
      bit ok;
      msg_in = DW'($urandom);
      msg_bytes = BW'(5);
      msg_last = 1'b0;
      msg_valid = 1'b1;
      wait_accept(ok);
      msg_valid = 1'b0;
      check_eq("err_set", err, 1);
      run_msg(abc, 1'b0, 1'b0, 0);
      check_eq("err_sticky", err, 1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("err_clear", err, 0);
      rst = 1'b0;
      @(negedge clk);
    end
`endif

    foreach (bounds[i]) begin
      run_msg(rand_msg(bounds[i]), 1'($urandom), 1'($urandom), $urandom_range(40));
    end
    for (int i = 0; i < 20; i++) begin
      run_msg(rand_msg($urandom_range(300)), 1'($urandom), 1'($urandom), $urandom_range(50));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md5_block_padder.md
# md5_block_padder

Parametrised MD5 message front-end that accepts arbitrary-length messages as a stream of DATA_W-bit beats and emits RFC 1321-padded 512-bit blocks to the `pancham` compression core. It replaces the single-beat, ≤128-bit message interface with multi-block messages. It handles the 0x80 marker, zero fill and the 64-bit little-endian bit-length field, including the extra padding block. Each block carries first/last flags so the core knows when to reload its IV and when to present the digest.

## Interface
- DATA_W, 128: input beat width in bits. Must be a multiple of 8 and divide 512 (8…512).
- LEN_W, 61: message byte-counter width. Bit length is {count,3'b000}, zero-extended to 64 bits.
- clk  in  1  clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- msg_in  in  [0:DATA_W-1]  message beat. First byte is in msg_in[0:7].
- msg_in_bytes  in  $clog2(DATA_W/8)+1  valid bytes in the beat, left-justified.
- msg_in_valid  in  1  beat valid.
- msg_in_last  in  1  final beat of the message.
- ready  out  1  beat accepted on an edge where msg_in_valid & ready.
- blk_out  out  [0:511]  padded block. Byte k is at blk_out[8k:8k+7].
- blk_out_valid  out  1  block valid.
- blk_out_first  out  1  first block of the message.
- blk_out_last  out  1  final block of the message (contains the length field).
- blk_out_ready  in  1  downstream accepts on an edge where blk_out_valid & blk_out_ready.
- err  out  1  sticky protocol error. Present only with MD5_PAD_ERR_EN.

## Operation
- Internal state: 64-byte buffer, byte pointer ptr (0..64), byte counter cnt (LEN_W bits, wraps modulo 2^LEN_W), first_pend flag, and a pending-final flag with a need80 bit.
- States: FILL, OUT_DATA, OUT_PAD, OUT_FINAL.
- FILL: ready=1. An accepted beat writes n bytes at ptr, then ptr+=n and cnt+=n.
  - Non-last beats are full: n = DATA_W/8.
  - Non-last beat with ptr reaching 64 → OUT_DATA.
- Last beat: let t = ptr+n.
  - t ≤ 55: write 0x80 at byte t, zero bytes t+1..55, write length in bytes 56..63 (LSB first) → OUT_FINAL.
  - 56 ≤ t ≤ 63: write 0x80 at byte t, zero the rest, set need80=0 → OUT_PAD.
  - t = 64: set need80=1 → OUT_PAD.
- OUT_DATA handshake: ptr←0 → FILL.
- OUT_PAD handshake: the buffer is reloaded on the same edge with 0x80 at byte 0 if need80 (else 0x00), zeros in bytes 1..55, and the length in bytes 56..63 → OUT_FINAL.
- OUT_FINAL handshake: clear ptr, cnt, need80; set first_pend → FILL.
- blk_out_first = first_pend in any OUT state. first_pend clears on the first block handshake.
- blk_out_last = 1 only in OUT_FINAL.
- msg_in_bytes=0 with msg_in_last=1 is legal. The empty message produces a single block: 80 00… with length 0.

## Timing
- Reset values: ready=0 during reset, and 1 on the first cycle after reset deasserts. blk_out_valid=0, blk_out_first=0, blk_out_last=0, blk_out=0, err=0, state=FILL, ptr=0, cnt=0, first_pend=1.
- Latency: blk_out_valid rises the cycle after the edge that accepts the completing beat. There is no combinational path from input to output.
- ready=0 in every OUT state; there is no skid buffer. Peak throughput is one block per 512/DATA_W+1 cycles.
- While blk_out_valid=1 and blk_out_ready=0, blk_out and its flags hold stable.
- A back-to-back new message may present on the cycle after the OUT_FINAL handshake.
- reset mid-message, in any state, discards the buffer and counters. The next cycle is the reset state.
- The length field is (cnt·8) mod 2^64, matching MD5 wrap-around.

## Configuration
- MD5_PAD_ERR_EN defined:
  - An accepted beat is illegal if it is non-last with msg_in_bytes ≠ DATA_W/8, or has msg_in_bytes > DATA_W/8.
  - An illegal beat is consumed but not written, and cnt is unchanged.
  - err sets and stays high until reset.
- MD5_PAD_ERR_EN undefined:
  - err port absent.
  - Non-last beats are treated as full.
  - msg_in_bytes > DATA_W/8 is clamped to DATA_W/8.

## Test plan
- "abc", DATA_W=128, one last beat with 3 bytes → one block 61 62 63 80 00…, bytes 56..63 = 18 00 00 00 00 00 00 00. first=last=1. Pancham digest 900150983cd24fb0d6963f7d28e17f72.
- Empty message (last beat, 0 bytes) → single block 80, 00×55, length 0. Digest d41d8cd98f00b204e9800998ecf8427e.
- 56-byte message, as 3 full beats plus a last beat of 8 bytes → two blocks. Block 1 has byte 56 = 0x80 with first=1, last=0. Block 2 is all zero except bytes 56..57 = C0 01, with first=0, last=1.
- 64-byte message → block 1 is the raw data. Block 2 is 80 00… with bytes 56..57 = 00 02. Also check the 55-byte case: single block, byte 55 = 0x80, bytes 56..57 = B8 01.
- Backpressure: hold blk_out_ready=0 for 5 cycles → blk_out and flags stable, ready=0, no beats lost. A 200-byte message yields 4 blocks with flags 1/0, 0/0, 0/0, 0/1.
- Reset asserted in OUT_DATA of a 2-block message, then "abc" sent → ready=1 one cycle after reset deasserts, and the abc block is correct with first=1. With MD5_PAD_ERR_EN, a non-last 5-byte beat sets err=1 and leaves cnt unchanged.
